// File: rtl/lsu_ctrl.sv
// ---------------------------------------------------------------------------
// lsu_ctrl - load/store controller between the CPU datapath and a byte-lane
// data memory.
//
// One request at a time is accepted through req/ready. The controller then
// addresses the memory, returns a one-cycle done pulse and, for loads, a
// right-justified and extended result. Misaligned or illegal-size requests
// never reach memory and complete one cycle after accept with err=1.
//
// Handshake: a request is taken on the rising clk edge where req & ready are
// both 1. ready is high only in IDLE. The requester keeps req and its
// operands stable until that edge. done is a single-cycle pulse, and err is
// meaningful only while done=1.
//
// Optional feature macro: LSU_SIGNEXT_EN. When defined, byte/half loads with
// sign=1 sign-extend. Otherwise all byte/half loads zero-extend.
//
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   req, we, size, sign  request strobe and attributes (sampled on accept)
//   addr, wdata          byte address and right-justified store data
//   ready, done, err     handshake and completion status
//   rdata                load result, held between successful loads
//   mem_addr, mem_sel    memory word address and 4-bit lane select
//   mem_wdata, mem_str   lane-positioned store word and write strobe
//   mem_rdata            right-justified memory read data
// ---------------------------------------------------------------------------
module lsu_ctrl #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 10
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    req,
   input  logic                    we,
   input  logic [1:0]              size,
   input  logic                    sign,
   input  logic [ADDR_WIDTH+1:0]   addr,
   input  logic [DATA_WIDTH-1:0]   wdata,
   output logic                    ready,
   output logic                    done,
   output logic                    err,
   output logic [DATA_WIDTH-1:0]   rdata,
   output logic [ADDR_WIDTH-1:0]   mem_addr,
   output logic [3:0]              mem_sel,
   output logic [DATA_WIDTH-1:0]   mem_wdata,
   output logic                    mem_str,
   input  logic [DATA_WIDTH-1:0]   mem_rdata
);

`ifdef LSU_SIGNEXT_EN
   localparam logic SIGNEXT = 1'b1;
`else
   localparam logic SIGNEXT = 1'b0;
`endif

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

   state_t                  state_q, state_d;
   logic                    we_q, sign_q, err_q;
   logic [1:0]              size_q;
   logic [ADDR_WIDTH+1:0]   addr_q;
   logic [DATA_WIDTH-1:0]   wdata_q, rdata_q;
   logic                    legal;
   logic                    mem_active;
   logic [3:0]              sel_calc;
   logic [DATA_WIDTH-1:0]   place_calc, load_ext;
   logic                    fill;
   logic [1:0]              offs;

   // Request legality is decided from the live inputs during IDLE so an
   // illegal request can skip memory entirely.
   always_comb begin
      legal = 1'b0;
      case (size)
         2'b00:   legal = 1'b1;
         2'b01:   legal = ~addr[0];
         2'b10:   legal = (addr[1:0] == 2'b00);
         default: legal = 1'b0;
      endcase
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (req) state_d = legal ? ISSUE : DONE;
         ISSUE:   state_d = we_q ? DONE : WAIT;
         WAIT:    state_d = DONE;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Lane select and store-word placement from the latched request.
   always_comb begin
      offs       = addr_q[1:0];
      sel_calc   = 4'b0000;
      place_calc = '0;
      case (size_q)
         2'b00: begin
            sel_calc   = 4'b0001 << offs;
            place_calc = {24'b0, wdata_q[7:0]} << {offs, 3'b000};
         end
         2'b01: begin
            sel_calc   = offs[1] ? 4'b1100 : 4'b0011;
            place_calc = offs[1] ? {wdata_q[15:0], 16'b0} : {16'b0, wdata_q[15:0]};
         end
         2'b10: begin
            sel_calc   = 4'b1111;
            place_calc = wdata_q;
         end
         default: begin
            sel_calc   = 4'b0000;
            place_calc = '0;
         end
      endcase
   end

   // Load extraction; fill is the extension bit for byte/half loads.
   always_comb begin
      fill     = 1'b0;
      load_ext = mem_rdata;
      case (size_q)
         2'b00: begin
            fill     = SIGNEXT & sign_q & mem_rdata[7];
            load_ext = {{24{fill}}, mem_rdata[7:0]};
         end
         2'b01: begin
            fill     = SIGNEXT & sign_q & mem_rdata[15];
            load_ext = {{16{fill}}, mem_rdata[15:0]};
         end
         default: load_ext = mem_rdata;
      endcase
   end

   always_comb begin
      mem_active = (state_q == ISSUE) || (state_q == WAIT);
      ready      = (state_q == IDLE);
      done       = (state_q == DONE);
      err        = done & err_q;
      mem_str    = (state_q == ISSUE) & we_q;
      mem_sel    = mem_active ? sel_calc : 4'b0000;
      mem_wdata  = mem_active ? place_calc : '0;
      mem_addr   = addr_q[ADDR_WIDTH+1:2];
      rdata      = rdata_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         we_q    <= 1'b0;
         sign_q  <= 1'b0;
         size_q  <= 2'b00;
         addr_q  <= '0;
         wdata_q <= '0;
         err_q   <= 1'b0;
         rdata_q <= '0;
      end else begin
         state_q <= state_d;
         if (state_q == IDLE && req) begin
            err_q <= ~legal;
            // An illegal request leaves the memory-side registers alone so
            // mem_addr keeps its previous value.
            if (legal) begin
               we_q    <= we;
               sign_q  <= sign;
               size_q  <= size;
               addr_q  <= addr;
               wdata_q <= wdata;
            end
         end
         if (state_q == WAIT) rdata_q <= load_ext;
      end
   end

endmodule

// File: tb/tb_lsu_ctrl.sv
module tb_lsu_ctrl;

  localparam int AW = 10;
`ifdef LSU_SIGNEXT_EN
  localparam bit SIGNEXT = 1'b1;
`else
  localparam bit SIGNEXT = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  logic          req = 1'b0, we = 1'b0, sign = 1'b0;
  logic [1:0]    size = 2'b00;
  logic [AW+1:0] addr = '0;
  logic [31:0]   wdata = '0;
  logic          ready, done, err, mem_str;
  logic [31:0]   rdata, mem_wdata, mem_rdata;
  logic [AW-1:0] mem_addr;
  logic [3:0]    mem_sel;

  lsu_ctrl #(.DATA_WIDTH(32), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .we(we), .size(size), .sign(sign),
    .addr(addr), .wdata(wdata), .ready(ready), .done(done), .err(err),
    .rdata(rdata), .mem_addr(mem_addr), .mem_sel(mem_sel),
    .mem_wdata(mem_wdata), .mem_str(mem_str), .mem_rdata(mem_rdata)
  );

  // ---------------- memory device (word array, byte lanes) ----------------
  logic [31:0] dev_mem [1024];

  always_comb begin
    mem_rdata = 32'h0;
    if (mem_sel[0])      mem_rdata = dev_mem[mem_addr];
    else if (mem_sel[1]) mem_rdata = dev_mem[mem_addr] >> 8;
    else if (mem_sel[2]) mem_rdata = dev_mem[mem_addr] >> 16;
    else if (mem_sel[3]) mem_rdata = dev_mem[mem_addr] >> 24;
  end

  always @(posedge clk) begin
    if (mem_str)
      for (int b = 0; b < 4; b++)
        if (mem_sel[b]) dev_mem[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
  end

  // ---------------- reference model (byte-addressed) ----------------
  logic [7:0]  ref_mem [256];
  logic [31:0] ref_rdata = 32'h0;
  logic [32:0] exp_q[$];   // {err, rdata} expected at each done
  logic [45:0] st_q[$];    // {word addr, sel, wdata} expected at each mem_str
  int n_checks = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic flag(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: event seen, none expected", name);
  endtask

  task automatic set_byte(input int a, input logic [7:0] v);
    ref_mem[a] = v;
    dev_mem[a/4][8*(a%4) +: 8] = v;
  endtask

  // Applies one request to the reference and queues the expected responses.
  task automatic model(input logic t_we, input logic [1:0] t_size, input logic t_sign,
                       input int a, input logic [31:0] wd, output int lat);
    int n;
    logic [63:0] m;
    logic [31:0] v;
    logic [3:0] sel;
    n = (t_size == 2'd0) ? 1 : (t_size == 2'd1) ? 2 : 4;
    m = (64'd1 << (8*n)) - 64'd1;
    if (t_size == 2'd3 || (a % n) != 0) begin
      exp_q.push_back({1'b1, ref_rdata});
      lat = 1;
      return;
    end
    if (t_we) begin
      for (int i = 0; i < n; i++) ref_mem[a+i] = wd[8*i +: 8];
      sel = 4'(((1 << n) - 1) << (a % 4));
      st_q.push_back({10'(a / 4), sel, 32'((wd & m[31:0]) << (8*(a % 4)))});
      lat = 2;
    end else begin
      v = 32'h0;
      for (int i = 0; i < n; i++) v[8*i +: 8] = ref_mem[a+i];
      if (SIGNEXT && t_sign && n < 4 && v[8*n-1]) v = v | ~m[31:0];
      ref_rdata = v;
      lat = 3;
    end
    exp_q.push_back({1'b0, ref_rdata});
  endtask

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    if (rst_n) begin
      if (mem_str) begin
        if (st_q.size() == 0) flag("unexpected_mem_str");
        else check("mem_store", {mem_addr, mem_sel, mem_wdata}, 64'(st_q.pop_front()));
      end
      if (done) begin
        if (exp_q.size() == 0) flag("unexpected_done");
        else begin
          logic [32:0] e;
          e = exp_q.pop_front();
          check("done_err", 64'(err), 64'(e[32]));
          check("done_rdata", 64'(rdata), 64'(e[31:0]));
        end
        check("done_mem_quiet", {mem_sel, mem_str}, 64'h0);
      end
      if (ready) check("idle_outputs", {mem_sel, mem_str, mem_wdata, done}, 64'h0);
    end
  end

  // ---------------- driver ----------------
  task automatic wait_ready(input string name);
    int w;
    w = 0;
    while (!ready && w < 20) begin @(negedge clk); w++; end
    if (!ready) flag({name, "_ready_timeout"});
  endtask

  task automatic wait_done(input string name, input int exp_lat);
    int lat;
    lat = 1;
    while (!done && lat < 8) begin @(negedge clk); lat++; end
    check({name, "_latency"}, 64'(lat), 64'(exp_lat));
  endtask

  // Called at a negedge; returns at the negedge where done is seen.
  task automatic send(input logic t_we, input logic [1:0] t_size, input logic t_sign,
                      input int a, input logic [31:0] wd, input string name);
    int exp_lat;
    req = 1'b1; we = t_we; size = t_size; sign = t_sign;
    addr = (AW+2)'(a); wdata = wd;
    wait_ready(name);
    model(t_we, t_size, t_sign, a, wd, exp_lat);
    @(posedge clk);
    @(negedge clk);
    req = 1'b0;
    wait_done(name, exp_lat);
  endtask

  initial begin
    int lat;
    for (int i = 0; i < 1024; i++) dev_mem[i] = 32'h0;
    for (int i = 0; i < 256; i++) set_byte(i, 8'($urandom));

    #1 rst_n = 1'b0;
    #1;
    check("rst_ready", 64'(ready), 64'h1);
    check("rst_outputs", {done, err, rdata, mem_addr, mem_sel, mem_wdata, mem_str}, 64'h0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Directed cases.
    send(1'b1, 2'd2, 1'b0, 'h010, 32'hDEADBEEF, "st_word");
    send(1'b1, 2'd0, 1'b0, 'h013, 32'h000000A5, "st_byte");
    set_byte('h012, 8'h80);
    send(1'b0, 2'd0, 1'b1, 'h012, 32'h0, "ld_byte_signed");
    check("ld_byte_value", 64'(rdata), SIGNEXT ? 64'hFFFFFF80 : 64'h00000080);
    set_byte('h006, 8'h34);
    set_byte('h007, 8'h12);
    send(1'b0, 2'd1, 1'b0, 'h006, 32'h0, "ld_half");
    check("ld_half_value", 64'(rdata), 64'h00001234);
    send(1'b0, 2'd2, 1'b0, 'h005, 32'h0, "err_misaligned");
    send(1'b1, 2'd3, 1'b0, 'h008, 32'h12345678, "err_size");
    check("err_rdata_held", 64'(rdata), 64'h00001234);

    // Reset during ISSUE of a store: strobe drops at once, no done.
    @(negedge clk);
    req = 1'b1; we = 1'b1; size = 2'd2; addr = 'h020; wdata = 32'hCAFEF00D;
    wait_ready("rst_store");
    st_q.push_back({10'h008, 4'hF, 32'hCAFEF00D});
    @(posedge clk);
    @(negedge clk);
    req = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("rst_mid_str", 64'(mem_str), 64'h0);
    check("rst_mid_ready", 64'(ready), 64'h1);
    check("rst_mid_outputs", {done, err, rdata, mem_addr, mem_sel, mem_wdata}, 64'h0);
    ref_rdata = 32'h0;
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_ready", 64'(ready), 64'h1);
    send(1'b0, 2'd2, 1'b0, 'h020, 32'h0, "ld_after_dropped_store");

    // req held high through a busy period: next accept only back in IDLE.
    req = 1'b1; we = 1'b1; size = 2'd1; sign = 1'b0; addr = 'h02A; wdata = 32'h0000BEEF;
    wait_ready("hold");
    model(1'b1, 2'd1, 1'b0, 'h02A, 32'h0000BEEF, lat);
    @(posedge clk);
    @(negedge clk); check("hold_busy_c1", 64'(ready), 64'h0);
    @(negedge clk); check("hold_busy_c2", 64'(ready), 64'h0);
    @(negedge clk); check("hold_idle_c3", 64'(ready), 64'h1);
    model(1'b1, 2'd1, 1'b0, 'h02A, 32'h0000BEEF, lat);
    @(posedge clk);
    @(negedge clk);
    req = 1'b0;
    wait_done("hold_second", lat);

    // Randomized traffic, biased toward aligned addresses.
    for (int k = 0; k < 300; k++) begin
      logic [1:0] s;
      int a;
      s = 2'($urandom_range(0, 3));
      a = $urandom_range(0, 255);
      if ($urandom_range(0, 3) != 0) a = a & ~((s == 2'd2) ? 3 : (s == 2'd1) ? 1 : 0);
      send(1'($urandom), s, 1'($urandom), a, $urandom, "rand");
    end

    repeat (4) @(negedge clk);
    check("exp_q_drained", 64'(exp_q.size()), 64'h0);
    check("st_q_drained", 64'(st_q.size()), 64'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
